// File: rtl/mii_pkg.sv
// Shared MII constants and receive FSM state type.
package mii_pkg;

    localparam logic [3:0]  MII_PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  MII_SFD_NIB      = 4'hD;
    localparam logic [31:0] CRC32_POLY_REFL  = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT       = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE    = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'd0,
        RX_PREAMBLE = 2'd1,
        RX_DATA     = 2'd2,
        RX_DROP     = 2'd3
    } rx_state_t;

endpackage

// File: rtl/crc32_byte.sv
// Combinational byte-wise update of a reflected CRC-32 register (no final XOR).
module crc32_byte
    import mii_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        logic [31:0] c;
        c = crc_i ^ {24'd0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/mii_rx_decoder.sv
// MII receive decoder: strips preamble/SFD, packs nibbles into bytes, checks
// the FCS and reports per-frame length and status on an end-of-frame pulse.
module mii_rx_decoder
    import mii_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int MIN_FRAME_BYTES = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        enet_rx_dv,
    input  logic        enet_rx_er,
    input  logic [3:0]  enet_rx_data,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic [15:0] rx_len,
    output logic        rx_crc_ok,
    output logic        rx_err
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_BYTES);
    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_BYTES);

    rx_state_t   state_q, state_d;
    logic        phase_q, phase_d;
    logic [3:0]  low_nib_q, low_nib_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic        frame_err_q, frame_err_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic [15:0] len_q, len_d;
    logic        crc_ok_q, crc_ok_d;
    logic        err_q, err_d;

    logic [7:0]  byte_in;
    logic [31:0] crc_next;
    logic        end_err;

    assign byte_in = {enet_rx_data, low_nib_q};

    crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (byte_in),
        .crc_o  (crc_next)
    );

    // A dangling low nibble at dv drop makes the frame odd-length.
    assign end_err = frame_err_q | phase_q | (cnt_q > MAX_LEN) | (cnt_q < MIN_LEN);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        low_nib_d   = low_nib_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        frame_err_d = frame_err_q;
        valid_d     = 1'b0;
        data_d      = data_q;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        len_d       = len_q;
        crc_ok_d    = crc_ok_q;
        err_d       = err_q;

        case (state_q)
            RX_IDLE: begin
                if (enet_rx_dv) begin
                    state_d = (enet_rx_data == MII_PREAMBLE_NIB) ? RX_PREAMBLE : RX_DROP;
                end
            end
            RX_PREAMBLE: begin
                if (!enet_rx_dv) begin
                    state_d = RX_IDLE;
                end else if (enet_rx_data == MII_SFD_NIB) begin
                    state_d     = RX_DATA;
                    phase_d     = 1'b0;
                    cnt_d       = 16'd0;
                    crc_d       = CRC32_INIT;
                    frame_err_d = 1'b0;
                end else if (enet_rx_data != MII_PREAMBLE_NIB) begin
                    state_d = RX_DROP;
                end
            end
            RX_DATA: begin
                if (!enet_rx_dv) begin
                    state_d  = RX_IDLE;
                    eof_d    = 1'b1;
                    len_d    = cnt_q;
                    err_d    = end_err;
                    crc_ok_d = (crc_q == CRC32_RESIDUE) && !end_err;
                end else begin
                    if (enet_rx_er) begin
                        frame_err_d = 1'b1;
                    end
                    if (!phase_q) begin
                        low_nib_d = enet_rx_data;
                        phase_d   = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        crc_d   = crc_next;
                        cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                        if (cnt_q < MAX_LEN) begin
                            valid_d = 1'b1;
                            data_d  = byte_in;
                            sof_d   = (cnt_q == 16'd0);
                        end
                    end
                end
            end
            RX_DROP: begin
                if (!enet_rx_dv) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= RX_IDLE;
            phase_q     <= 1'b0;
            low_nib_q   <= 4'd0;
            cnt_q       <= 16'd0;
            crc_q       <= CRC32_INIT;
            frame_err_q <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= 8'd0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            len_q       <= 16'd0;
            crc_ok_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            low_nib_q   <= low_nib_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            frame_err_q <= frame_err_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            len_q       <= len_d;
            crc_ok_q    <= crc_ok_d;
            err_q       <= err_d;
        end
    end

    assign rx_valid  = valid_q;
    assign rx_data   = data_q;
    assign rx_sof    = sof_q;
    assign rx_eof    = eof_q;
    assign rx_len    = len_q;
    assign rx_crc_ok = crc_ok_q;
    assign rx_err    = err_q;

endmodule

// File: tb/tb_mii_rx_decoder.sv
// Randomized frame-level bench for mii_rx_decoder against a whole-frame reference model.
module tb_mii_rx_decoder;

    localparam int MAX_B = 1518;
    localparam int MIN_B = 64;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        enet_rx_dv;
    logic        enet_rx_er;
    logic [3:0]  enet_rx_data;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_sof;
    logic        rx_eof;
    logic [15:0] rx_len;
    logic        rx_crc_ok;
    logic        rx_err;

    mii_rx_decoder #(
        .MAX_FRAME_BYTES (MAX_B),
        .MIN_FRAME_BYTES (MIN_B)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .enet_rx_dv   (enet_rx_dv),
        .enet_rx_er   (enet_rx_er),
        .enet_rx_data (enet_rx_data),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_sof       (rx_sof),
        .rx_eof       (rx_eof),
        .rx_len       (rx_len),
        .rx_crc_ok    (rx_crc_ok),
        .rx_err       (rx_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed output stream, accumulated over the whole run.
    logic [7:0]  got_bytes[$];
    int          sof_cnt = 0;
    int          last_sof_pos = -1;
    int          eof_cnt = 0;
    int          stray_cnt = 0;
    logic [15:0] eof_len = 16'd0;
    logic        eof_ok = 1'b0;
    logic        eof_err = 1'b0;

    always @(negedge i_clk) begin
        if (rx_valid) begin
            got_bytes.push_back(rx_data);
            if (rx_sof) begin
                sof_cnt++;
                last_sof_pos = got_bytes.size() - 1;
            end
        end else if (rx_sof) begin
            stray_cnt++;
        end
        if (rx_eof) begin
            eof_cnt++;
            eof_len = rx_len;
            eof_ok  = rx_crc_ok;
            eof_err = rx_err;
            if (rx_valid) stray_cnt++;
        end
    end

    logic [3:0]  pre_q[$];
    logic [3:0]  nib_q[$];
    logic [7:0]  exp_bytes[$];
    logic        exp_eof;
    logic        exp_ok;
    logic        exp_err;
    logic [15:0] exp_len;

    function automatic logic [31:0] crc_calc(input logic [7:0] b[$], input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic make_frame(input int payload_len, input int pre_len);
        logic [7:0]  b[$];
        logic [31:0] fcs;
        pre_q.delete();
        repeat (pre_len - 1) pre_q.push_back(4'h5);
        pre_q.push_back(4'hD);
        for (int i = 0; i < payload_len; i++) b.push_back(8'($urandom));
        fcs = ~crc_calc(b, payload_len);
        for (int k = 0; k < 4; k++) b.push_back(fcs[8*k +: 8]);
        nib_q.delete();
        foreach (b[i]) begin
            nib_q.push_back(b[i][3:0]);
            nib_q.push_back(b[i][7:4]);
        end
    endtask

    // Frame-level expectation: good FCS means trailing four bytes equal ~CRC of the rest.
    task automatic build_expected(input int er_at, input int reset_at);
        logic        pre_ok;
        int          n_nib;
        int          n_seen;
        int          n_whole;
        logic [7:0]  whole[$];
        logic [31:0] fcs_calc;
        logic [31:0] fcs_rx;
        pre_ok = (pre_q.size() >= 2) && (pre_q[pre_q.size()-1] == 4'hD);
        for (int i = 0; i < pre_q.size() - 1; i++) if (pre_q[i] != 4'h5) pre_ok = 1'b0;
        n_nib   = nib_q.size();
        n_whole = n_nib / 2;
        n_seen  = (reset_at >= 0) ? reset_at : n_nib;
        for (int i = 0; i < n_whole; i++) whole.push_back({nib_q[2*i+1], nib_q[2*i]});
        exp_bytes.delete();
        exp_eof = 1'b0;
        exp_len = 16'd0;
        exp_ok  = 1'b0;
        exp_err = 1'b0;
        if (!pre_ok) return;
        for (int i = 0; (i < n_seen / 2) && (i < MAX_B); i++) exp_bytes.push_back(whole[i]);
        if (reset_at >= 0) return;
        exp_eof = 1'b1;
        exp_len = (n_whole > 65535) ? 16'hFFFF : 16'(n_whole);
        exp_err = (er_at >= 0 && er_at < n_nib) || (n_nib % 2 == 1) || (n_whole > MAX_B) || (n_whole < MIN_B);
        if (n_whole >= 4) begin
            fcs_calc = ~crc_calc(whole, n_whole - 4);
            fcs_rx   = {whole[n_whole-1], whole[n_whole-2], whole[n_whole-3], whole[n_whole-4]};
            exp_ok   = (fcs_calc == fcs_rx) && !exp_err;
        end
    endtask

    task automatic drive(input logic dv, input logic er, input logic [3:0] d);
        enet_rx_dv   = dv;
        enet_rx_er   = er;
        enet_rx_data = d;
        @(negedge i_clk);
        #1;
    endtask

    task automatic apply_stimulus(input int er_at, input int reset_at, input int gap);
        int b_bytes;
        int b_sof;
        int b_eof;
        int b_stray;
        int n_got;
        int n_bad;
        build_expected(er_at, reset_at);
        b_bytes = got_bytes.size();
        b_sof   = sof_cnt;
        b_eof   = eof_cnt;
        b_stray = stray_cnt;
        foreach (pre_q[i]) drive(1'b1, 1'b0, pre_q[i]);
        for (int i = 0; i < nib_q.size(); i++) begin
            if (i == reset_at) i_reset = 1'b1;
            drive(1'b1, (i == er_at), nib_q[i]);
            if (i == reset_at) begin
                i_reset = 1'b0;
                check_output("reset_mid_frame",
                    32'({rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err, rx_data, rx_len}), 32'd0);
            end
            if (i == 1 && reset_at < 0)
                check_output("sof_latency", 32'({rx_valid, rx_sof}),
                    (exp_bytes.size() > 0) ? 32'd3 : 32'd0);
        end
        drive(1'b0, 1'b0, 4'd0);
        check_output("eof_latency", 32'(rx_eof), 32'(exp_eof));
        repeat (gap - 1) drive(1'b0, 1'b0, 4'($urandom));
        n_got = got_bytes.size() - b_bytes;
        check_output("byte_count", 32'(n_got), 32'(exp_bytes.size()));
        n_bad = 0;
        for (int i = 0; i < n_got && i < exp_bytes.size(); i++)
            if (got_bytes[b_bytes + i] !== exp_bytes[i]) n_bad++;
        check_output("byte_data_mismatches", 32'(n_bad), 32'd0);
        check_output("sof_count", 32'(sof_cnt - b_sof), (exp_bytes.size() > 0) ? 32'd1 : 32'd0);
        if (exp_bytes.size() > 0 && sof_cnt != b_sof)
            check_output("sof_position", 32'(last_sof_pos - b_bytes), 32'd0);
        check_output("stray_sof_or_overlap", 32'(stray_cnt - b_stray), 32'd0);
        check_output("eof_count", 32'(eof_cnt - b_eof), 32'(exp_eof));
        if (exp_eof) begin
            check_output("eof_status", 32'({eof_len, eof_ok, eof_err}), 32'({exp_len, exp_ok, exp_err}));
            check_output("status_hold", 32'({rx_len, rx_crc_ok, rx_err}), 32'({exp_len, exp_ok, exp_err}));
        end
    endtask

    initial begin
        i_reset      = 1'b1;
        enet_rx_dv   = 1'b0;
        enet_rx_er   = 1'b0;
        enet_rx_data = 4'd0;
        @(negedge i_clk);
        #1;
        repeat (3) drive(1'b1, 1'b0, 4'hD);
        check_output("reset_values",
            32'({rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err, rx_data, rx_len}), 32'd0);
        i_reset = 1'b0;
        drive(1'b0, 1'b0, 4'd0);

        $display("[TB] good 64-byte frame");
        make_frame(60, 16);
        apply_stimulus(-1, -1, 3);

        $display("[TB] flipped payload nibble");
        make_frame(60, 16);
        nib_q[21] = nib_q[21] ^ 4'h4;
        apply_stimulus(-1, -1, 3);

        $display("[TB] rx_er at byte 30");
        make_frame(60, 16);
        apply_stimulus(60, -1, 3);

        $display("[TB] odd nibble truncation");
        make_frame(60, 16);
        void'(nib_q.pop_back());
        apply_stimulus(-1, -1, 3);

        $display("[TB] bad preamble then good frame");
        make_frame(60, 2);
        pre_q = '{4'h5, 4'h5, 4'h7, 4'hD};
        apply_stimulus(-1, -1, 2);
        make_frame(60, 8);
        apply_stimulus(-1, -1, 2);

        $display("[TB] reset at byte 20 then back-to-back frames");
        make_frame(60, 16);
        nib_q[41] = 4'hA;
        apply_stimulus(-1, 40, 2);
        make_frame(60, 16);
        apply_stimulus(-1, -1, 1);
        make_frame(70, 4);
        apply_stimulus(-1, -1, 1);

        $display("[TB] length boundaries");
        pre_q = '{4'h5, 4'hD};
        nib_q.delete();
        apply_stimulus(-1, -1, 1);
        make_frame(59, 3);
        apply_stimulus(-1, -1, 2);
        make_frame(MAX_B - 4, 3);
        apply_stimulus(-1, -1, 2);
        make_frame(MAX_B - 3, 3);
        apply_stimulus(-1, -1, 2);

        $display("[TB] randomized frames");
        for (int t = 0; t < 12; t++) begin
            int pl;
            int er;
            pl = $urandom_range(0, 100);
            make_frame(pl, $urandom_range(2, 16));
            if ($urandom_range(0, 4) == 0) pre_q[0] = 4'($urandom);
            if ($urandom_range(0, 3) == 0) void'(nib_q.pop_back());
            er = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nib_q.size() - 1) : -1;
            apply_stimulus(er, -1, $urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
